// File: rtl/fft_stream_ctrl.sv
// fft_stream_ctrl: bus-programmable sequencer that streams one frame of
// complex samples from the sample RAM into a streaming FFT core, captures the
// FFT results into a result RAM and raises a done/timeout interrupt.
// Optional continuous mode re-arms immediately for back-to-back frames.
module fft_stream_ctrl #(
    parameter int N_POINTS   = 64,
    parameter int IN_WIDTH   = 12,
    parameter int OUT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TO_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic [3:0]             we_i,
    input  logic [3:0]             addr_i,
    input  logic [31:0]            data_i,
    output logic [31:0]            data_o,
    output logic                   smp_rd_en_o,
    output logic [ADDR_WIDTH-1:0]  smp_addr_o,
    input  logic [31:0]            smp_r_i,
    input  logic [31:0]            smp_i_i,
    output logic                   fft_rst_o,
    output logic                   fft_in_valid_o,
    output logic [IN_WIDTH-1:0]    fft_din_r_o,
    output logic [IN_WIDTH-1:0]    fft_din_i_o,
    input  logic                   fft_out_valid_i,
    input  logic [OUT_WIDTH-1:0]   fft_dout_r_i,
    input  logic [OUT_WIDTH-1:0]   fft_dout_i_i,
    output logic                   res_we_o,
    output logic [ADDR_WIDTH-1:0]  res_addr_o,
    output logic [2*OUT_WIDTH-1:0] res_data_o,
    output logic                   busy_o,
    output logic                   irq_o
);

    // Index counters need one extra bit so they can hold N_POINTS itself.
    localparam int CW = $clog2(N_POINTS) + 1;
    localparam logic [CW-1:0] N_CNT = CW'(N_POINTS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         k_q;        // sample read index
    logic [CW-1:0]         j_q;        // result write index
    logic                  valid_q;    // read strobe delayed to match RAM latency
    logic [TO_WIDTH-1:0]   idle_q;     // DRAIN cycles since the last FFT output
    logic                  cont_q;
    logic                  irq_en_q;
    logic                  done_q;
    logic                  timeout_q;
    logic [15:0]           frames_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [TO_WIDTH-1:0]   tolim_q;
    logic [31:0]           data_q;

    logic        wr_w;
    logic        rd_w;
    logic        ctrl_wr_w;
    logic        sts_wr_w;
    logic        base_wr_w;
    logic        to_wr_w;
    logic        start_w;
    logic        abort_w;
    logic        busy_w;
    logic        rd_en_w;
    logic        cap_w;
    logic        done_set_w;
    logic        to_set_w;
    logic [31:0] rd_mux_w;

    // Bus decode, strobe generation and the status read mux.
    always_comb begin
        wr_w       = en_i && (we_i != 4'b0000);
        rd_w       = en_i && (we_i == 4'b0000);
        ctrl_wr_w  = wr_w && (addr_i[3:2] == 2'd0);
        sts_wr_w   = wr_w && (addr_i[3:2] == 2'd1);
        base_wr_w  = wr_w && (addr_i[3:2] == 2'd2);
        to_wr_w    = wr_w && (addr_i[3:2] == 2'd3);
        start_w    = ctrl_wr_w && data_i[0];
        abort_w    = ctrl_wr_w && data_i[3];
        busy_w     = (state_q != S_IDLE);
        rd_en_w    = (state_q == S_FEED) && (k_q < N_CNT);
        cap_w      = ((state_q == S_FEED) || (state_q == S_DRAIN))
                     && fft_out_valid_i && (j_q < N_CNT);
        // Abort suppresses any status update from the state being left.
        done_set_w = (state_q == S_DONE) && !abort_w;
        to_set_w   = (state_q == S_DRAIN) && !abort_w && (j_q != N_CNT)
                     && (tolim_q != '0) && (idle_q == tolim_q);
        rd_mux_w   = 32'h0;
        case (addr_i[3:2])
            2'd0:    rd_mux_w = {29'b0, irq_en_q, cont_q, 1'b0};
            2'd1:    rd_mux_w = {frames_q, 13'b0, timeout_q, done_q, busy_w};
            2'd2:    rd_mux_w = 32'(base_q);
            default: rd_mux_w = 32'(tolim_q);
        endcase
    end

    // Frame sequencer: read indexing, capture indexing and the DRAIN watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            j_q     <= '0;
            valid_q <= 1'b0;
            idle_q  <= '0;
        end else begin
            valid_q <= rd_en_w && !abort_w;
            if (cap_w) begin
                j_q <= j_q + CW'(1);
            end
            if (abort_w) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_w) begin
                            state_q <= S_FEED;
                            k_q     <= '0;
                            j_q     <= '0;
                        end
                    end
                    S_FEED: begin
                        idle_q <= '0;
                        if (rd_en_w) begin
                            k_q <= k_q + CW'(1);
                        end
                        // k reaches N_POINTS in the cycle in_valid carries the last sample.
                        if (k_q == N_CNT) begin
                            state_q <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (j_q == N_CNT) begin
                            state_q <= S_DONE;
                        end else if (to_set_w) begin
                            state_q <= S_IDLE;
                        end else begin
                            idle_q <= fft_out_valid_i ? '0 : idle_q + TO_WIDTH'(1);
                        end
                    end
                    default: begin
                        if (cont_q) begin
                            state_q <= S_FEED;
                            k_q     <= '0;
                            j_q     <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Programmable registers, sticky status (set beats clear) and read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            frames_q  <= '0;
            base_q    <= '0;
            tolim_q   <= '0;
            data_q    <= '0;
        end else begin
            if (ctrl_wr_w) begin
                cont_q   <= data_i[1];
                irq_en_q <= data_i[2];
            end
            if (base_wr_w && !busy_w) begin
                base_q <= data_i[ADDR_WIDTH-1:0];
            end
            if (to_wr_w) begin
                tolim_q <= data_i[TO_WIDTH-1:0];
            end
            if (done_set_w) begin
                done_q <= 1'b1;
            end else if (sts_wr_w && data_i[1]) begin
                done_q <= 1'b0;
            end
            if (to_set_w) begin
                timeout_q <= 1'b1;
            end else if (sts_wr_w && data_i[2]) begin
                timeout_q <= 1'b0;
            end
            if (done_set_w) begin
                frames_q <= (sts_wr_w ? 16'h0 : frames_q) + 16'h1;
            end else if (sts_wr_w) begin
                frames_q <= '0;
            end
            if (rd_w) begin
                data_q <= rd_mux_w;
            end
        end
    end

    assign data_o         = data_q;
    assign smp_rd_en_o    = rd_en_w;
    assign smp_addr_o     = rd_en_w ? (base_q + ADDR_WIDTH'(k_q)) : '0;
    assign fft_rst_o      = (state_q == S_IDLE) || (state_q == S_DONE);
    assign fft_in_valid_o = valid_q;
    assign fft_din_r_o    = smp_r_i[IN_WIDTH-1:0];
    assign fft_din_i_o    = smp_i_i[IN_WIDTH-1:0];
    assign res_we_o       = cap_w;
    assign res_addr_o     = cap_w ? ADDR_WIDTH'(j_q) : '0;
    assign res_data_o     = cap_w ? {fft_dout_r_i, fft_dout_i_i} : '0;
    assign busy_o         = busy_w;
    assign irq_o          = irq_en_q && (done_q || timeout_q);

    // Bits of the bus and sample words that this block does not consume.
    logic unused_ok;
    assign unused_ok = ^{data_i, addr_i[1:0], smp_r_i, smp_i_i};

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Self-checking bench for fft_stream_ctrl: register table vectors, then frame
// sequences against a sample-RAM model and a fixed-latency FFT model, with a
// scoreboard of expected result writes filled from the read strobes.
module tb_fft_stream_ctrl;

    localparam int N  = 64;
    localparam int IW = 12;
    localparam int OW = 16;
    localparam int AW = 16;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_i;
    logic [3:0]    we_i;
    logic [3:0]    addr_i;
    logic [31:0]   data_i;
    logic [31:0]   data_o;
    logic          smp_rd_en_o;
    logic [AW-1:0] smp_addr_o;
    logic [31:0]   smp_r_i = '0;
    logic [31:0]   smp_i_i = '0;
    logic          fft_rst_o;
    logic          fft_in_valid_o;
    logic [IW-1:0] fft_din_r_o;
    logic [IW-1:0] fft_din_i_o;
    logic          fft_out_valid_i;
    logic [OW-1:0] fft_dout_r_i;
    logic [OW-1:0] fft_dout_i_i;
    logic          res_we_o;
    logic [AW-1:0] res_addr_o;
    logic [2*OW-1:0] res_data_o;
    logic          busy_o;
    logic          irq_o;

    always #5 clk = ~clk;

    fft_stream_ctrl #(
        .N_POINTS  (N),
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .ADDR_WIDTH(AW),
        .TO_WIDTH  (TW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en_i),
        .we_i           (we_i),
        .addr_i         (addr_i),
        .data_i         (data_i),
        .data_o         (data_o),
        .smp_rd_en_o    (smp_rd_en_o),
        .smp_addr_o     (smp_addr_o),
        .smp_r_i        (smp_r_i),
        .smp_i_i        (smp_i_i),
        .fft_rst_o      (fft_rst_o),
        .fft_in_valid_o (fft_in_valid_o),
        .fft_din_r_o    (fft_din_r_o),
        .fft_din_i_o    (fft_din_i_o),
        .fft_out_valid_i(fft_out_valid_i),
        .fft_dout_r_i   (fft_dout_r_i),
        .fft_dout_i_i   (fft_dout_i_i),
        .res_we_o       (res_we_o),
        .res_addr_o     (res_addr_o),
        .res_data_o     (res_data_o),
        .busy_o         (busy_o),
        .irq_o          (irq_o)
    );

    // Sample RAM: word at address a is a (real) and ~a (imag), one cycle latency.
    always @(posedge clk) begin
        if (smp_rd_en_o) begin
            smp_r_i <= {16'h0, smp_addr_o};
            smp_i_i <= ~{16'h0, smp_addr_o};
        end
    end

    // FFT model: two-cycle pipeline, r+3 and i^0x8000, stops after out_limit outputs.
    logic          v1 = 1'b0;
    logic          ov = 1'b0;
    logic [OW-1:0] r1 = '0;
    logic [OW-1:0] i1 = '0;
    logic [OW-1:0] dr = '0;
    logic [OW-1:0] di = '0;
    int            out_cnt = 0;
    int            out_limit = 32'h4000_0000;

    always @(posedge clk) begin
        if (fft_rst_o) begin
            v1      <= 1'b0;
            ov      <= 1'b0;
            out_cnt <= 0;
        end else begin
            v1 <= fft_in_valid_o;
            r1 <= 16'(fft_din_r_o) + 16'd3;
            i1 <= 16'(fft_din_i_o) ^ 16'h8000;
            if (v1 && (out_cnt < out_limit)) begin
                ov      <= 1'b1;
                dr      <= r1;
                di      <= i1;
                out_cnt <= out_cnt + 1;
            end else begin
                ov <= 1'b0;
            end
        end
    end

    assign fft_out_valid_i = ov;
    assign fft_dout_r_i    = dr;
    assign fft_dout_i_i    = di;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } res_t;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    res_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    logic [15:0] base_tb = '0;
    int          rd_k, rd_cnt, rd_first, rd_last;
    int          iv_cnt, iv_first, iv_last;
    int          n_res, done_cycles, run, max_run;
    logic [31:0] rdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [15:0] a);
        logic [15:0] r;
        logic [15:0] i;
        r = {4'h0, a[11:0]} + 16'd3;
        i = {4'h0, ~a[11:0]} ^ 16'h8000;
        return {r, i};
    endfunction

    // Per-cycle observation: address stream, scoreboard push/pop, timing marks.
    task automatic monitor();
        int          rel;
        logic [15:0] idx;
        logic [15:0] ea;
        res_t        e;
        rel = cyc - start_cyc;
        if (smp_rd_en_o) begin
            idx = 16'(rd_k % N);
            ea  = base_tb + idx;
            check("rd_addr", 32'(smp_addr_o), 32'(ea));
            sb_q.push_back('{addr: idx, data: exp_word(ea)});
            if (rd_cnt == 0) rd_first = rel;
            rd_last = rel;
            rd_cnt++;
            rd_k++;
        end
        if (fft_in_valid_o) begin
            if (iv_cnt == 0) iv_first = rel;
            iv_last = rel;
            iv_cnt++;
        end
        if (res_we_o) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL res_unexpected: got write at 0x%0h, expected none", res_addr_o);
            end else begin
                e = sb_q.pop_front();
                check("res_addr", 32'(res_addr_o), 32'(e.addr));
                check("res_data", res_data_o, e.data);
            end
            n_res++;
        end
        if (busy_o && fft_rst_o) begin
            done_cycles++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        en_i   = 1'b1;
        we_i   = 4'hF;
        addr_i = a;
        data_i = d;
        tick();
        en_i = 1'b0;
        we_i = 4'h0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        en_i   = 1'b1;
        we_i   = 4'h0;
        addr_i = a;
        tick();
        en_i = 1'b0;
        d    = data_o;
    endtask

    task automatic new_test(input logic [15:0] b);
        base_tb     = b;
        start_cyc   = cyc;
        rd_k        = 0;
        rd_cnt      = 0;
        rd_first    = -1;
        rd_last     = -1;
        iv_cnt      = 0;
        iv_first    = -1;
        iv_last     = -1;
        n_res       = 0;
        done_cycles = 0;
        run         = 0;
        max_run     = 0;
        sb_q.delete();
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && busy_o; i++) tick();
        check("idle_wait", 32'(busy_o), 32'h0);
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{4'hC, 32'h0000_1234, 32'h0000_1234};
        vt[1] = '{4'hC, 32'hFFFF_0042, 32'h0000_0042};
        vt[2] = '{4'h0, 32'h0000_0006, 32'h0000_0006};
        vt[3] = '{4'h0, 32'h0000_0002, 32'h0000_0002};
        vt[4] = '{4'h0, 32'h0000_0000, 32'h0000_0000};
        vt[5] = '{4'h4, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[6] = '{4'hC, 32'h0000_0000, 32'h0000_0000};
        vt[7] = '{4'h8, 32'h1234_ABCD, 32'h0000_ABCD};

        rst    = 1'b1;
        en_i   = 1'b0;
        we_i   = 4'h0;
        addr_i = 4'h0;
        data_i = 32'h0;
        new_test(16'h0);
        tick();
        tick();
        check("rst_data_o", data_o, 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_fft_rst", 32'(fft_rst_o), 32'h1);
        check("rst_rd_en", 32'(smp_rd_en_o), 32'h0);
        check("rst_in_valid", 32'(fft_in_valid_o), 32'h0);
        check("rst_res_we", 32'(res_we_o), 32'h0);
        rst = 1'b0;
        tick();

        // Register table: write, read back, compare.
        for (int v = 0; v < 8; v++) begin
            bus_write(vt[v].addr, vt[v].wdata);
            bus_read(vt[v].addr, rdata);
            $display("vec %0d: addr=0x%0h wdata=0x%08h read=0x%08h exp=0x%08h",
                     v, vt[v].addr, vt[v].wdata, rdata, vt[v].exp);
            check("reg_vec", rdata, vt[v].exp);
        end
        bus_write(4'hC, 32'h77);
        check("read_hold", data_o, vt[7].exp);
        bus_write(4'hC, 32'h0);

        // Single frame, BASE=0x10, IRQ enabled.
        bus_write(4'h8, 32'h10);
        bus_write(4'h0, 32'h4);
        new_test(16'h0010);
        bus_write(4'h0, 32'h5);
        check("busy_cycle1", 32'(busy_o), 32'h1);
        wait_idle(400);
        check("rd_first", rd_first, 1);
        check("rd_last", rd_last, N);
        check("iv_first", iv_first, 2);
        check("iv_last", iv_last, N + 1);
        check("rd_count", rd_cnt, N);
        check("res_count", n_res, N);
        check("sb_empty", sb_q.size(), 0);
        bus_read(4'h4, rdata);
        check("status_done", rdata, 32'h0001_0002);
        check("irq_set", 32'(irq_o), 32'h1);
        bus_write(4'h4, 32'h2);
        check("irq_cleared", 32'(irq_o), 32'h0);
        bus_read(4'h4, rdata);
        check("status_w1c", rdata, 32'h0);

        // Address wrap from 0xFFF8.
        bus_write(4'h8, 32'hFFF8);
        new_test(16'hFFF8);
        bus_write(4'h0, 32'h1);
        wait_idle(400);
        check("wrap_res_count", n_res, N);
        bus_read(4'h4, rdata);
        check("wrap_status", rdata, 32'h0001_0002);
        bus_write(4'h4, 32'h6);

        // Continuous mode: three frames, CONT cleared during the third.
        bus_write(4'h8, 32'h20);
        new_test(16'h0020);
        bus_write(4'h0, 32'h3);
        for (int i = 0; i < 600 && done_cycles < 2; i++) tick();
        check("cont_two_done", done_cycles, 2);
        repeat (10) tick();
        bus_write(4'h0, 32'h0);
        wait_idle(400);
        check("cont_done_cycles", done_cycles, 3);
        check("cont_gap", max_run, 1);
        check("cont_rd_count", rd_cnt, 3 * N);
        check("cont_res_count", n_res, 3 * N);
        bus_read(4'h4, rdata);
        check("cont_status", rdata, 32'h0003_0002);
        check("cont_fft_rst", 32'(fft_rst_o), 32'h1);
        bus_write(4'h4, 32'h2);

        // Timeout: FFT produces only 10 outputs.
        bus_write(4'hC, 32'd20);
        bus_write(4'h8, 32'h10);
        out_limit = 10;
        new_test(16'h0010);
        bus_write(4'h0, 32'h1);
        wait_idle(600);
        check("to_res_count", n_res, 10);
        check("to_no_done", done_cycles, 0);
        bus_read(4'h4, rdata);
        check("to_status", rdata, 32'h0000_0004);
        out_limit = 32'h4000_0000;
        bus_write(4'hC, 32'h0);
        bus_write(4'h4, 32'h4);
        bus_read(4'h4, rdata);
        check("to_cleared", rdata, 32'h0);

        // Abort at FEED cycle 30, then a clean frame.
        new_test(16'h0010);
        bus_write(4'h0, 32'h1);
        repeat (29) tick();
        bus_write(4'h0, 32'h8);
        check("abort_busy", 32'(busy_o), 32'h0);
        check("abort_fft_rst", 32'(fft_rst_o), 32'h1);
        check("abort_rd_count", rd_cnt, 30);
        bus_read(4'h4, rdata);
        check("abort_status", rdata, 32'h0);
        new_test(16'h0010);
        bus_write(4'h0, 32'h1);
        wait_idle(400);
        check("post_abort_res", n_res, N);
        bus_read(4'h4, rdata);
        check("post_abort_status", rdata, 32'h0001_0002);
        bus_write(4'h4, 32'h6);

        // START and ABORT in one write.
        bus_write(4'h0, 32'h9);
        check("start_abort_busy", 32'(busy_o), 32'h0);
        tick();
        check("start_abort_rd", 32'(smp_rd_en_o), 32'h0);

        // START and BASE write while busy are ignored.
        new_test(16'h0010);
        bus_write(4'h0, 32'h1);
        repeat (5) tick();
        bus_write(4'h8, 32'h40);
        bus_write(4'h0, 32'h1);
        wait_idle(400);
        check("busy_start_rd", rd_cnt, N);
        check("busy_start_res", n_res, N);
        bus_read(4'h4, rdata);
        check("busy_start_status", rdata, 32'h0001_0002);
        bus_read(4'h8, rdata);
        check("busy_base_kept", rdata, 32'h10);

        // Asynchronous reset in DRAIN with DONE still pending and IRQ enabled.
        new_test(16'h0010);
        bus_write(4'h0, 32'h5);
        bus_read(4'h4, rdata);
        while ((cyc - start_cyc) < N + 2) tick();
        check("drain_busy", 32'(busy_o), 32'h1);
        check("drain_fft_rst", 32'(fft_rst_o), 32'h0);
        check("drain_irq", 32'(irq_o), 32'h1);
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy_o), 32'h0);
        check("arst_fft_rst", 32'(fft_rst_o), 32'h1);
        check("arst_irq", 32'(irq_o), 32'h0);
        check("arst_data_o", data_o, 32'h0);
        check("arst_res_we", 32'(res_we_o), 32'h0);
        check("arst_res_data", res_data_o, 32'h0);
        check("arst_smp_addr", 32'(smp_addr_o), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        bus_read(4'h4, rdata);
        check("arst_status", rdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
